// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand-mux forwarding select encodings.
// Used by the hazard controller and by the EX operand mux that consumes its selects.
package pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one EX source operand; youngest producer (MEM) wins over WB.
// Latency: combinational. Backpressure: none, pure decode of shadow-register state.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_regwrite,
    output logic [1:0]      sel
);

    // Register 0 is hardwired, so a write to it never produces a forwardable value.
    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src))
            sel = FWD_MEM;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))
            sel = FWD_WB;
    end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding selects and load-use stall/flush control from shadow EX/MEM/WB registers.
// Latency: selects combinational from shadow regs; shadow regs advance every clock. Stall holds PC and IF/ID one cycle.
module forward_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            branch_taken,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            pc_we,
    output logic            ifid_we,
    output logic            flush,
    output logic [15:0]     stall_cnt
);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } ex_t;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic            regwrite;
    } wr_t;

    ex_t  ex_q;
    wr_t  mem_q;
    wr_t  wb_q;

    logic stall;
    logic stall_eff;
    logic bubble;

    assign stall = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
                   ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));

    // A taken branch squashes the consumer anyway, so the stall is dropped and not counted.
    assign flush     = branch_taken;
    assign stall_eff = stall && !flush;
    assign bubble    = stall || flush;
    assign pc_we     = !stall_eff;
    assign ifid_we   = !stall_eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
        end else begin
            if (bubble) begin
                ex_q <= '0;
            end else begin
                ex_q.valid    <= id_valid;
                ex_q.rs       <= id_rs;
                ex_q.rt       <= id_rt;
                ex_q.rd       <= id_rd;
                ex_q.regwrite <= id_regwrite;
                ex_q.memread  <= id_memread;
            end
            mem_q.rd       <= ex_q.rd;
            mem_q.regwrite <= ex_q.regwrite && ex_q.valid;
            wb_q           <= mem_q;
            if (stall_eff && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .src          (ex_q.rs),
        .mem_rd       (mem_q.rd),
        .mem_regwrite (mem_q.regwrite),
        .wb_rd        (wb_q.rd),
        .wb_regwrite  (wb_q.regwrite),
        .sel          (fwd_a)
    );

    fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .src          (ex_q.rt),
        .mem_rd       (mem_q.rd),
        .mem_regwrite (mem_q.regwrite),
        .wb_rd        (wb_q.rd),
        .wb_regwrite  (wb_q.regwrite),
        .sel          (fwd_b)
    );

endmodule
